reg_file_clr: RTL and testbench

Parametrised register file for the datapath: two combinational read ports and one synchronous write port, with same-cycle write-to-read bypass, an optional hardwired-zero entry 0, and a hardware clear sequencer. The sequencer zeroes every entry after reset so the array needs no reset fan-out. It replaces the fixed 32x32 register file between decode (read addresses) and writeback (write port).

---
 rtl/reg_file_clr.sv | 132 +++++++++++++
 tb/tb_reg_file_clr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_clr.sv
// reg_file_clr: parametrised register file with two combinational read ports,
// one synchronous write port, optional same-cycle write bypass, optional
// hardwired-zero entry 0, and a clear sequencer that zeroes the array after
// reset so the storage itself carries no reset.
module reg_file_clr #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   idx_r;
    logic                busy_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                clr_en_s;
    logic                wr_en_s;

    // Read-port selection: blocked while clearing, hardwired zero, bypass, array.
    function automatic logic [DATA_W-1:0] sel_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] entry,
        input logic              blocked,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] res;
        if (blocked) begin
            res = ZERO_DAT;
        end else if ((ZERO_REG != 0) && (addr == ZERO_IDX)) begin
            res = ZERO_DAT;
        end else if ((BYPASS != 0) && we && (waddr == addr)) begin
            res = wdata;
        end else begin
            res = entry;
        end
        return res;
    endfunction

    // Clear sequencer: walks the index over every entry after reset, then hands over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLEAR;
            idx_r   <= ZERO_IDX;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                CLEAR: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= READY;
                        idx_r   <= ZERO_IDX;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= CLEAR;
                        idx_r   <= idx_r + ONE_IDX;
                        busy_r  <= 1'b1;
                    end
                end
                READY: begin
                    state_r <= READY;
                    idx_r   <= idx_r;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= CLEAR;
                    idx_r   <= ZERO_IDX;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    // Array write enables: clear writes only when reset is released; user writes only in READY.
    always_comb begin
        clr_en_s = 1'b0;
        wr_en_s  = 1'b0;
        if ((state_r == CLEAR) && !rst) begin
            clr_en_s = 1'b1;
        end else begin
            clr_en_s = 1'b0;
        end
        if ((state_r == READY) && we3 && !((ZERO_REG != 0) && (A3 == ZERO_IDX))) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array (no reset): zeroed by the sequencer, written by the write port.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem_r[idx_r] <= ZERO_DAT;
        end else if (wr_en_s) begin
            mem_r[A3] <= WD3;
        end
    end

    // Combinational read ports, forced to zero while the clear sequence runs.
    always_comb begin
        rd1 = ZERO_DAT;
        rd2 = ZERO_DAT;
        rd1 = sel_read(A1, mem_r[A1], busy_r, we3, A3, WD3);
        rd2 = sel_read(A2, mem_r[A2], busy_r, we3, A3, WD3);
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed testbench for reg_file_clr: three instances (default 32x32,
// 32x32 without bypass/zero-register, and 8x16).
module tb_reg_file_clr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_we;
    logic [4:0]  a_a3, a_a1, a_a2;
    logic [31:0] a_wd, a_rd1, a_rd2;
    logic        a_busy;

    logic        b_we;
    logic [4:0]  b_a3, b_a1, b_a2;
    logic [31:0] b_wd, b_rd1, b_rd2;
    logic        b_busy;

    logic        c_we;
    logic [2:0]  c_a3, c_a1, c_a2;
    logic [15:0] c_wd, c_rd1, c_rd2;
    logic        c_busy;

    int total = 0;
    int bad   = 0;

    reg_file_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .we3(a_we), .A3(a_a3), .WD3(a_wd),
        .A1(a_a1), .A2(a_a2), .rd1(a_rd1), .rd2(a_rd2), .busy(a_busy)
    );

    reg_file_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .we3(b_we), .A3(b_a3), .WD3(b_wd),
        .A1(b_a1), .A2(b_a2), .rd1(b_rd1), .rd2(b_rd2), .busy(b_busy)
    );

    reg_file_clr #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .rst(rst), .we3(c_we), .A3(c_a3), .WD3(c_wd),
        .A1(c_a1), .A2(c_a2), .rd1(c_rd1), .rd2(c_rd2), .busy(c_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until instance A leaves CLEAR (bounded).
    task automatic wait_clear(output int n);
        n = 0;
        while (a_busy && n < 200) begin
            step();
            n++;
        end
    endtask

    // Read every address of A and B and require zero.
    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            a_a1 = 5'(i);
            a_a2 = 5'(31 - i);
            b_a1 = 5'(i);
            b_a2 = 5'(31 - i);
            #1;
            check_eq({tag, "_a_rd1"}, a_rd1, 32'h0000_0000);
            check_eq({tag, "_a_rd2"}, a_rd2, 32'h0000_0000);
            check_eq({tag, "_b_rd1"}, b_rd1, 32'h0000_0000);
        end
    endtask

    initial begin
        int n;
        int c_n;

        a_we = 1'b1; a_a3 = 5'd7; a_wd = 32'hA5A5_A5A5; a_a1 = 5'd7; a_a2 = 5'd7;
        b_we = 1'b0; b_a3 = 5'd0; b_wd = 32'h0;         b_a1 = 5'd0; b_a2 = 5'd0;
        c_we = 1'b0; c_a3 = 3'd0; c_wd = 16'h0;         c_a1 = 3'd0; c_a2 = 3'd0;

        // reset state
        step();
        step();
        check_eq("rst_busy_a", {31'd0, a_busy}, 32'd1);
        check_eq("rst_busy_c", {31'd0, c_busy}, 32'd1);
        check_eq("rst_rd1", a_rd1, 32'h0);
        check_eq("rst_rd2", a_rd2, 32'h0);

        // clear latency with write held on entry 7 during CLEAR
        rst = 1'b0;
        n = 0;
        c_n = -1;
        while (a_busy && n < 200) begin
            step();
            n++;
            if (!c_busy && c_n < 0) c_n = n;
            if (n == 3) check_eq("clear_rd_blocked", a_rd1, 32'h0);
        end
        a_we = 1'b0;
        check_eq("clear_edges_a", 32'(n), 32'd32);
        check_eq("clear_edges_c", 32'(c_n), 32'd8);
        #1;
        check_eq("blocked_wr_r7", a_rd1, 32'h0);
        check_all_zero("init");

        // fill with ones, then reset from READY and re-clear
        for (int i = 0; i < 32; i++) begin
            a_we = 1'b1; a_a3 = 5'(i); a_wd = 32'hFFFF_FFFF;
            b_we = 1'b1; b_a3 = 5'(i); b_wd = 32'hFFFF_FFFF;
            step();
        end
        a_we = 1'b0; b_we = 1'b0;
        a_a1 = 5'd9; a_a2 = 5'd0; b_a1 = 5'd5;
        #1;
        check_eq("fill_a_r9", a_rd1, 32'hFFFF_FFFF);
        check_eq("fill_a_r0", a_rd2, 32'h0);
        check_eq("fill_b_r5", b_rd1, 32'hFFFF_FFFF);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_busy", {31'd0, a_busy}, 32'd1);
        check_eq("async_rd1", a_rd1, 32'h0);
        step();
        rst = 1'b0;
        wait_clear(n);
        check_eq("reclear_edges", 32'(n), 32'd32);
        check_all_zero("reclr");

        // write with bypass (A) and without (B)
        a_we = 1'b1; a_a3 = 5'd5; a_wd = 32'hDEAD_BEEF; a_a1 = 5'd5; a_a2 = 5'd5;
        b_we = 1'b1; b_a3 = 5'd5; b_wd = 32'hDEAD_BEEF; b_a1 = 5'd5; b_a2 = 5'd5;
        #1;
        check_eq("byp_rd1", a_rd1, 32'hDEAD_BEEF);
        check_eq("byp_rd2", a_rd2, 32'hDEAD_BEEF);
        check_eq("nobyp_old", b_rd1, 32'h0);
        step();
        a_we = 1'b0; b_we = 1'b0;
        #1;
        check_eq("wr_next_a", a_rd1, 32'hDEAD_BEEF);
        check_eq("wr_next_b", b_rd2, 32'hDEAD_BEEF);

        // zero register
        a_we = 1'b1; a_a3 = 5'd0; a_wd = 32'h1234_5678; a_a1 = 5'd0;
        b_we = 1'b1; b_a3 = 5'd0; b_wd = 32'h1234_5678; b_a1 = 5'd0;
        #1;
        check_eq("zero_wrcyc_a", a_rd1, 32'h0);
        check_eq("zero_wrcyc_b", b_rd1, 32'h0);
        step();
        a_we = 1'b0; b_we = 1'b0;
        #1;
        check_eq("zero_later_a", a_rd1, 32'h0);
        check_eq("nozero_b", b_rd1, 32'h1234_5678);

        // full-width bypass compare: r3 vs r19
        a_we = 1'b1; a_a3 = 5'd3; a_wd = 32'h0000_0055; a_a1 = 5'd3; a_a2 = 5'd19;
        #1;
        check_eq("byp_match", a_rd1, 32'h55);
        check_eq("byp_nomatch", a_rd2, 32'h0);
        step();
        a_we = 1'b0;
        #1;
        check_eq("r3_written", a_rd1, 32'h55);

        // reset in READY, then reset again mid-clear at index 10
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("midclr_busy", {31'd0, a_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midclr_rst_rd", a_rd1, 32'h0);
        step();
        rst = 1'b0;
        wait_clear(n);
        check_eq("midclr_edges", 32'(n), 32'd32);
        a_a1 = 5'd3; a_a2 = 5'd5;
        #1;
        check_eq("r3_recleared", a_rd1, 32'h0);
        check_eq("r5_recleared", a_rd2, 32'h0);

        // small instance: 16-bit data, 8 entries
        c_we = 1'b1; c_a3 = 3'd7; c_wd = 16'hBEEF; c_a1 = 3'd7; c_a2 = 3'd6;
        #1;
        check_eq("c_byp", {16'h0, c_rd1}, 32'h0000_BEEF);
        step();
        c_we = 1'b0;
        #1;
        check_eq("c_r7", {16'h0, c_rd1}, 32'h0000_BEEF);
        check_eq("c_r6", {16'h0, c_rd2}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
